// File: rtl/ctrl_packet_injector.sv
// Registered forward/backward pass-through to the first PE, with host-driven control
// read/write packet injection between upstream packets and read-response snooping.
module ctrl_packet_injector #(
  parameter int DATA_WIDTH                  = 512,
  parameter int STREAM_ID_NUM               = 16,
  parameter int CHUNK_ID_NUM                = 32,
  parameter int CHANNEL_ID_NUM              = 1024,
  parameter int STATE_WIDTH                 = 32,
  parameter int INSTRUCTION_WIDTH           = 2,
  parameter int INSTRUCTION_PARAMETER_WIDTH = 16,
  parameter logic [INSTRUCTION_WIDTH-1:0] INSTRUCTION_CMD_IDLE = '0,
  parameter int CTRL_STREAM_ID              = 0,
  parameter int TIMEOUT_CYCLES              = 1024,
  parameter int CP_R_CTRL_READ_REQUEST_32b  = 0,
  parameter int CP_R_CTRL_WRITE_32b         = 1,
  parameter int CP_A_CTRL_READ_RESPONSE_32b = 1,
  localparam int STREAM_ID_WIDTH  = $clog2(STREAM_ID_NUM),
  localparam int CHUNK_ID_WIDTH   = $clog2(CHUNK_ID_NUM),
  localparam int CHANNEL_ID_WIDTH = $clog2(CHANNEL_ID_NUM),
  localparam int NUM_32B_FIELDS   = DATA_WIDTH / 32
) (
  input  logic                                   clk,
  input  logic                                   rstnIn,
  input  logic [DATA_WIDTH-1:0]                  up_Data,
  input  logic [1:0]                             up_Type,
  input  logic                                   up_Last,
  input  logic [STREAM_ID_WIDTH-1:0]             up_StreamID,
  input  logic [CHUNK_ID_WIDTH-1:0]              up_ChunkID,
  input  logic [CHANNEL_ID_WIDTH-1:0]            up_ChannelID,
  input  logic [STATE_WIDTH-1:0]                 up_State,
  output logic [DATA_WIDTH-1:0]                  dn_Data,
  output logic [1:0]                             dn_Type,
  output logic                                   dn_Last,
  output logic [STREAM_ID_WIDTH-1:0]             dn_StreamID,
  output logic [CHUNK_ID_WIDTH-1:0]              dn_ChunkID,
  output logic [CHANNEL_ID_WIDTH-1:0]            dn_ChannelID,
  output logic [STATE_WIDTH-1:0]                 dn_State,
  input  logic [INSTRUCTION_WIDTH-1:0]           dn_InstructionType,
  input  logic [STREAM_ID_WIDTH-1:0]             dn_InstructionStreamID,
  input  logic [CHANNEL_ID_WIDTH-1:0]            dn_InstructionChannelID,
  input  logic [INSTRUCTION_PARAMETER_WIDTH-1:0] dn_InstructionParameter,
  output logic [INSTRUCTION_WIDTH-1:0]           up_InstructionType,
  output logic [STREAM_ID_WIDTH-1:0]             up_InstructionStreamID,
  output logic [CHANNEL_ID_WIDTH-1:0]            up_InstructionChannelID,
  output logic [INSTRUCTION_PARAMETER_WIDTH-1:0] up_InstructionParameter,
  input  logic [DATA_WIDTH-1:0]                  ret_Data,
  input  logic [1:0]                             ret_Type,
  input  logic [CHUNK_ID_WIDTH-1:0]              ret_ChunkID,
  input  logic [STATE_WIDTH-1:0]                 ret_State,
  input  logic                                   cmd_valid,
  output logic                                   cmd_ready,
  input  logic                                   cmd_write,
  input  logic [CHANNEL_ID_WIDTH-1:0]            cmd_target,
  input  logic [STATE_WIDTH-1:0]                 cmd_addr,
  input  logic [31:0]                            cmd_wdata,
  output logic                                   rsp_valid,
  output logic [31:0]                            rsp_data,
  output logic                                   rsp_err
);

  localparam int TIMER_WIDTH = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CHUNK_ID_WIDTH-2:0] OP_WR  = (CHUNK_ID_WIDTH-1)'(CP_R_CTRL_WRITE_32b);
  localparam logic [CHUNK_ID_WIDTH-2:0] OP_RD  = (CHUNK_ID_WIDTH-1)'(CP_R_CTRL_READ_REQUEST_32b);
  localparam logic [CHUNK_ID_WIDTH-2:0] OP_RSP = (CHUNK_ID_WIDTH-1)'(CP_A_CTRL_READ_RESPONSE_32b);
  localparam logic [TIMER_WIDTH-1:0]    TIMER_LAST = TIMER_WIDTH'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, SEND, WAIT_RSP} state_t;

  state_t                      state, state_next;
  logic [TIMER_WIDTH-1:0]      timer;
  logic                        in_packet;
  logic                        cmd_write_q;
  logic [CHANNEL_ID_WIDTH-1:0] cmd_target_q;
  logic [STATE_WIDTH-1:0]      cmd_addr_q;
  logic [31:0]                 cmd_wdata_q;
  logic                        accept, inject, rsp_match, finish_ok, finish_to;
  logic                        unused_ret;

  assign unused_ret = ^{ret_Data[DATA_WIDTH-1:32], ret_Type[0]};

  assign rsp_match = ret_Type[1] && !ret_ChunkID[CHUNK_ID_WIDTH-1]
                  && (ret_ChunkID[CHUNK_ID_WIDTH-2:0] == OP_RSP)
                  && (ret_State == cmd_addr_q);

  always_comb begin
    state_next = state;
    accept     = 1'b0;
    inject     = 1'b0;
    finish_ok  = 1'b0;
    finish_to  = 1'b0;
    unique case (state)
      IDLE: if (cmd_valid && cmd_ready) begin
        accept     = 1'b1;
        state_next = SEND;
      end
      // Only a true gap between packets may carry the control packet.
      SEND: if ((up_Type == '0) && !in_packet) begin
        inject     = 1'b1;
        state_next = cmd_write_q ? IDLE : WAIT_RSP;
      end
      WAIT_RSP: begin
        if (rsp_match) begin
          finish_ok  = 1'b1;
          state_next = IDLE;
        end else if (timer == TIMER_LAST) begin
          finish_to  = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstnIn) begin
      state                   <= IDLE;
      timer                   <= '0;
      in_packet               <= 1'b0;
      cmd_ready               <= 1'b0;
      rsp_valid               <= 1'b0;
      rsp_err                 <= 1'b0;
      rsp_data                <= '0;
      cmd_write_q             <= 1'b0;
      cmd_target_q            <= '0;
      cmd_addr_q              <= '0;
      cmd_wdata_q             <= '0;
      dn_Data                 <= '0;
      dn_Type                 <= '0;
      dn_Last                 <= 1'b0;
      dn_StreamID             <= '0;
      dn_ChunkID              <= '0;
      dn_ChannelID            <= '0;
      dn_State                <= '0;
      up_InstructionType      <= INSTRUCTION_CMD_IDLE;
      up_InstructionStreamID  <= '0;
      up_InstructionChannelID <= '0;
      up_InstructionParameter <= '0;
    end else begin
      state     <= state_next;
      cmd_ready <= (state_next == IDLE);
      rsp_valid <= finish_ok || finish_to;

      if (accept) begin
        cmd_write_q  <= cmd_write;
        cmd_target_q <= cmd_target;
        cmd_addr_q   <= cmd_addr;
        cmd_wdata_q  <= cmd_wdata;
      end

      if (up_Type != '0) in_packet <= !up_Last;

      if (inject)                timer <= '0;
      else if (state == WAIT_RSP) timer <= timer + 1'b1;

      if (finish_ok) begin
        rsp_data <= ret_Data[31:0];
        rsp_err  <= 1'b0;
      end else if (finish_to) begin
        rsp_data <= '0;
        rsp_err  <= 1'b1;
      end

      if (inject) begin
        dn_Data      <= cmd_write_q ? {NUM_32B_FIELDS{cmd_wdata_q}} : '0;
        dn_Type      <= 2'b10;
        dn_Last      <= 1'b1;
        dn_StreamID  <= STREAM_ID_WIDTH'(CTRL_STREAM_ID);
        dn_ChunkID   <= {1'b1, cmd_write_q ? OP_WR : OP_RD};
        dn_ChannelID <= cmd_target_q;
        dn_State     <= cmd_addr_q;
      end else begin
        dn_Data      <= up_Data;
        dn_Type      <= up_Type;
        dn_Last      <= up_Last;
        dn_StreamID  <= up_StreamID;
        dn_ChunkID   <= up_ChunkID;
        dn_ChannelID <= up_ChannelID;
        dn_State     <= up_State;
      end

      up_InstructionType      <= dn_InstructionType;
      up_InstructionStreamID  <= dn_InstructionStreamID;
      up_InstructionChannelID <= dn_InstructionChannelID;
      up_InstructionParameter <= dn_InstructionParameter;
    end
  end

endmodule

// File: tb/tb_ctrl_packet_injector.sv
// Bench for ctrl_packet_injector: table-driven pass-through vectors plus hand-written
// inject/read/timeout/reset sequences, checked through expectation queues.
module tb_ctrl_packet_injector;

  logic         clk = 1'b0;
  logic         rstnIn;
  logic [511:0] up_Data, dn_Data, ret_Data;
  logic [1:0]   up_Type, dn_Type, ret_Type;
  logic         up_Last, dn_Last;
  logic [3:0]   up_StreamID, dn_StreamID;
  logic [4:0]   up_ChunkID, dn_ChunkID, ret_ChunkID;
  logic [9:0]   up_ChannelID, dn_ChannelID;
  logic [31:0]  up_State, dn_State, ret_State;
  logic [1:0]   dn_InstructionType, up_InstructionType;
  logic [3:0]   dn_InstructionStreamID, up_InstructionStreamID;
  logic [9:0]   dn_InstructionChannelID, up_InstructionChannelID;
  logic [15:0]  dn_InstructionParameter, up_InstructionParameter;
  logic         cmd_valid, cmd_ready, cmd_write;
  logic [9:0]   cmd_target;
  logic [31:0]  cmd_addr, cmd_wdata;
  logic         rsp_valid, rsp_err;
  logic [31:0]  rsp_data;

  ctrl_packet_injector #(.TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .rstnIn(rstnIn),
    .up_Data(up_Data), .up_Type(up_Type), .up_Last(up_Last), .up_StreamID(up_StreamID),
    .up_ChunkID(up_ChunkID), .up_ChannelID(up_ChannelID), .up_State(up_State),
    .dn_Data(dn_Data), .dn_Type(dn_Type), .dn_Last(dn_Last), .dn_StreamID(dn_StreamID),
    .dn_ChunkID(dn_ChunkID), .dn_ChannelID(dn_ChannelID), .dn_State(dn_State),
    .dn_InstructionType(dn_InstructionType), .dn_InstructionStreamID(dn_InstructionStreamID),
    .dn_InstructionChannelID(dn_InstructionChannelID), .dn_InstructionParameter(dn_InstructionParameter),
    .up_InstructionType(up_InstructionType), .up_InstructionStreamID(up_InstructionStreamID),
    .up_InstructionChannelID(up_InstructionChannelID), .up_InstructionParameter(up_InstructionParameter),
    .ret_Data(ret_Data), .ret_Type(ret_Type), .ret_ChunkID(ret_ChunkID), .ret_State(ret_State),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write), .cmd_target(cmd_target),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] typ; logic last; logic [3:0] sid; logic [4:0] chunk; logic [9:0] chan;
    logic [31:0] st; logic [511:0] data;
    logic [1:0] ityp; logic [3:0] isid; logic [9:0] ichan; logic [15:0] ipar;
  } beat_t;
  typedef struct { beat_t in; beat_t exp; } vec_t;
  typedef struct { logic [31:0] data; logic err; int unsigned lat; } rsp_t;

  beat_t exp_q[$];
  rsp_t  rsp_q[$];
  vec_t  vecs[$];
  int unsigned n_vec = 0;
  int unsigned n_err = 0;
  beat_t idle;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_data(input string name, input logic [511:0] act, input logic [511:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic beat_t mk_beat(input logic [1:0] typ, input logic last, input logic [3:0] sid,
                                    input logic [4:0] chunk, input logic [9:0] chan, input logic [31:0] st,
                                    input logic [31:0] word, input logic [1:0] ityp, input logic [3:0] isid,
                                    input logic [9:0] ichan, input logic [15:0] ipar);
    beat_t b;
    b.typ = typ; b.last = last; b.sid = sid; b.chunk = chunk; b.chan = chan; b.st = st;
    for (int unsigned i = 0; i < 16; i++) b.data[i*32 +: 32] = word ^ i;
    b.ityp = ityp; b.isid = isid; b.ichan = ichan; b.ipar = ipar;
    return b;
  endfunction

  function automatic beat_t mk_inject(input logic wr, input logic [9:0] tgt, input logic [31:0] addr,
                                      input logic [31:0] wdata);
    beat_t b;
    logic [31:0] w;
    w = wr ? wdata : 32'h0;
    b = mk_beat(2'b10, 1'b1, 4'd0, wr ? 5'b10001 : 5'b10000, tgt, addr, 32'h0, 2'd0, 4'd0, 10'd0, 16'd0);
    for (int unsigned i = 0; i < 16; i++) b.data[i*32 +: 32] = w;
    return b;
  endfunction

  task automatic step(input beat_t drv, input beat_t exp);
    beat_t e;
    up_Type = drv.typ; up_Last = drv.last; up_StreamID = drv.sid; up_ChunkID = drv.chunk;
    up_ChannelID = drv.chan; up_State = drv.st; up_Data = drv.data;
    dn_InstructionType = drv.ityp; dn_InstructionStreamID = drv.isid;
    dn_InstructionChannelID = drv.ichan; dn_InstructionParameter = drv.ipar;
    exp_q.push_back(exp);
    @(posedge clk); #1;
    e = exp_q.pop_front();
    chk("dn_hdr", 64'({dn_Type, dn_Last, dn_StreamID, dn_ChunkID, dn_ChannelID, dn_State}),
                  64'({e.typ, e.last, e.sid, e.chunk, e.chan, e.st}));
    chk_data("dn_data", dn_Data, e.data);
    chk("up_instr", 64'({up_InstructionType, up_InstructionStreamID, up_InstructionChannelID, up_InstructionParameter}),
                    64'({e.ityp, e.isid, e.ichan, e.ipar}));
  endtask

  task automatic send_cmd(input logic wr, input logic [9:0] tgt, input logic [31:0] addr, input logic [31:0] wd);
    chk("cmd_ready_idle", 64'(cmd_ready), 64'd1);
    cmd_valid = 1'b1; cmd_write = wr; cmd_target = tgt; cmd_addr = addr; cmd_wdata = wd;
    step(idle, idle);
    cmd_valid = 1'b0;
    chk("cmd_ready_busy", 64'(cmd_ready), 64'd0);
  endtask

  // good_cyc = wait cycle (1 = first cycle after inject) whose edge sees the matching response; 0 = none
  task automatic run_read(input logic [31:0] addr, input int unsigned good_cyc, input logic [31:0] rdata,
                          input int unsigned exp_lat, input logic exp_err, input logic [31:0] exp_data);
    rsp_t e;
    logic seen;
    int unsigned lat;
    send_cmd(1'b0, 10'd9, addr, 32'hFFFF_FFFF);
    step(idle, mk_inject(1'b0, 10'd9, addr, 32'h0));
    rsp_q.push_back('{exp_data, exp_err, exp_lat});
    seen = 1'b0; lat = 0;
    for (int unsigned c = 1; c <= 20 && !seen; c++) begin
      ret_Type = 2'b00; ret_ChunkID = 5'd0; ret_State = 32'h0; ret_Data = '0;
      if (c == 1) begin
        ret_Type = 2'b10; ret_ChunkID = 5'b00001; ret_State = addr + 32'd4; ret_Data[31:0] = 32'hBAD0;
      end
      if (c == 2) begin
        ret_Type = 2'b10; ret_ChunkID = 5'b10001; ret_State = addr; ret_Data[31:0] = 32'hBAD1;
      end
      if (c == good_cyc) begin
        ret_Type = 2'b11; ret_ChunkID = 5'b00001; ret_State = addr;
        ret_Data = {16{32'h7777_0000}}; ret_Data[31:0] = rdata;
      end
      @(posedge clk); #1;
      if (rsp_valid) begin seen = 1'b1; lat = c; end
    end
    ret_Type = 2'b00; ret_ChunkID = 5'd0; ret_State = 32'h0; ret_Data = '0;
    e = rsp_q.pop_front();
    chk("rsp_seen", 64'(seen), 64'd1);
    chk("rsp_latency", 64'(lat), 64'(e.lat));
    chk("rsp_data", 64'(rsp_data), 64'(e.data));
    chk("rsp_err", 64'(rsp_err), 64'(e.err));
    step(idle, idle);
    chk("rsp_pulse_end", 64'(rsp_valid), 64'd0);
    chk("rsp_hold", 64'({rsp_err, rsp_data}), 64'({e.err, e.data}));
    chk("cmd_ready_after_rsp", 64'(cmd_ready), 64'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    beat_t b1, b2, bub, b3, b4;
    int unsigned pulses;
    idle = mk_beat(2'b00, 1'b0, 4'd0, 5'd0, 10'd0, 32'h0, 32'h0, 2'd0, 4'd0, 10'd0, 16'd0);
    rstnIn = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_target = '0; cmd_addr = '0; cmd_wdata = '0;
    ret_Type = '0; ret_ChunkID = '0; ret_State = '0; ret_Data = '0;
    up_Type = '0; up_Last = 1'b0; up_StreamID = '0; up_ChunkID = '0; up_ChannelID = '0; up_State = '0;
    up_Data = {16{32'h3C3C_3C3C}};
    dn_InstructionType = 2'd2; dn_InstructionStreamID = 4'd7; dn_InstructionChannelID = 10'd9;
    dn_InstructionParameter = 16'h1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_dn_type", 64'(dn_Type), 64'd0);
    chk("rst_up_itype", 64'(up_InstructionType), 64'd0);
    chk("rst_cmd_ready", 64'(cmd_ready), 64'd0);
    chk("rst_rsp", 64'({rsp_valid, rsp_err}), 64'd0);
    rstnIn = 1'b1;
    @(posedge clk); #1;
    chk("cmd_ready_release", 64'(cmd_ready), 64'd1);

    // pass-through table: forward beats and backward instructions, nothing injected
    vecs.push_back('{idle, idle});
    vecs.push_back('{mk_beat(2'b11, 1'b1, 4'd5, 5'd3, 10'd1023, 32'hFFFF_0000, 32'h0F0F_1234, 2'd0, 4'd0, 10'd0, 16'd0),
                     mk_beat(2'b11, 1'b1, 4'd5, 5'd3, 10'd1023, 32'hFFFF_0000, 32'h0F0F_1234, 2'd0, 4'd0, 10'd0, 16'd0)});
    vecs.push_back('{mk_beat(2'b00, 1'b0, 4'd0, 5'd0, 10'd0, 32'h0, 32'h0, 2'd1, 4'd2, 10'd5, 16'h0040),
                     mk_beat(2'b00, 1'b0, 4'd0, 5'd0, 10'd0, 32'h0, 32'h0, 2'd1, 4'd2, 10'd5, 16'h0040)});
    vecs.push_back('{mk_beat(2'b01, 1'b0, 4'd15, 5'd31, 10'd2, 32'h8000_0001, 32'hAAAA_5555, 2'd3, 4'd15, 10'd1023, 16'hFFFF),
                     mk_beat(2'b01, 1'b0, 4'd15, 5'd31, 10'd2, 32'h8000_0001, 32'hAAAA_5555, 2'd3, 4'd15, 10'd1023, 16'hFFFF)});
    vecs.push_back('{mk_beat(2'b01, 1'b1, 4'd1, 5'd16, 10'd512, 32'h0000_00C8, 32'h1357_9BDF, 2'd2, 4'd8, 10'd256, 16'h8001),
                     mk_beat(2'b01, 1'b1, 4'd1, 5'd16, 10'd512, 32'h0000_00C8, 32'h1357_9BDF, 2'd2, 4'd8, 10'd256, 16'h8001)});
    vecs.push_back('{mk_beat(2'b10, 1'b1, 4'd0, 5'b10001, 10'd3, 32'h10, 32'hFEDC_BA98, 2'd0, 4'd0, 10'd0, 16'd0),
                     mk_beat(2'b10, 1'b1, 4'd0, 5'b10001, 10'd3, 32'h10, 32'hFEDC_BA98, 2'd0, 4'd0, 10'd0, 16'd0)});
    for (int unsigned i = 0; i < vecs.size(); i++) step(vecs[i].in, vecs[i].exp);

    // write injected into an idle upstream
    send_cmd(1'b1, 10'd3, 32'h10, 32'hA5A5_0001);
    step(idle, mk_inject(1'b1, 10'd3, 32'h10, 32'hA5A5_0001));
    step(idle, idle);
    chk("cmd_ready_after_write", 64'(cmd_ready), 64'd1);

    // command arrives on beat 1 of a 4-beat packet with a bubble: inject waits for the gap after Last
    b1  = mk_beat(2'b01, 1'b0, 4'd3, 5'd2, 10'd11, 32'h100, 32'h1111_0000, 2'd0, 4'd0, 10'd0, 16'd0);
    b2  = mk_beat(2'b01, 1'b0, 4'd3, 5'd2, 10'd11, 32'h101, 32'h2222_0000, 2'd0, 4'd0, 10'd0, 16'd0);
    bub = mk_beat(2'b00, 1'b0, 4'd0, 5'd0, 10'd0, 32'h0, 32'h5555_0000, 2'd0, 4'd0, 10'd0, 16'd0);
    b3  = mk_beat(2'b01, 1'b0, 4'd3, 5'd2, 10'd11, 32'h102, 32'h3333_0000, 2'd0, 4'd0, 10'd0, 16'd0);
    b4  = mk_beat(2'b01, 1'b1, 4'd3, 5'd2, 10'd11, 32'h103, 32'h4444_0000, 2'd0, 4'd0, 10'd0, 16'd0);
    chk("cmd_ready_pkt", 64'(cmd_ready), 64'd1);
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_target = 10'd7; cmd_addr = 32'h30; cmd_wdata = 32'hDEAD_BEEF;
    step(b1, b1);
    cmd_valid = 1'b0;
    chk("cmd_ready_pkt_busy", 64'(cmd_ready), 64'd0);
    step(b2, b2);
    step(bub, bub);
    step(b3, b3);
    step(b4, b4);
    step(idle, mk_inject(1'b1, 10'd7, 32'h30, 32'hDEAD_BEEF));
    step(idle, idle);
    chk("cmd_ready_after_pkt", 64'(cmd_ready), 64'd1);

    // read matched after 7 cycles, earlier non-matching responses ignored
    run_read(32'h20, 7, 32'h0000_1234, 7, 1'b0, 32'h0000_1234);
    // no response: timeout error 8 cycles after inject
    run_read(32'h40, 0, 32'h0, 8, 1'b1, 32'h0);
    // response on the timeout cycle: match wins
    run_read(32'h60, 8, 32'hCAFE_0002, 8, 1'b0, 32'hCAFE_0002);

    // reset in the middle of a read wait
    send_cmd(1'b0, 10'd4, 32'h50, 32'h0);
    step(idle, mk_inject(1'b0, 10'd4, 32'h50, 32'h0));
    step(idle, idle);
    step(idle, idle);
    rstnIn = 1'b0;
    pulses = 0;
    repeat (2) begin
      @(posedge clk); #1;
      if (rsp_valid) pulses++;
    end
    chk("cmd_ready_in_reset", 64'(cmd_ready), 64'd0);
    rstnIn = 1'b1;
    @(posedge clk); #1;
    chk("cmd_ready_after_reset", 64'(cmd_ready), 64'd1);
    repeat (12) begin
      if (rsp_valid) pulses++;
      @(posedge clk); #1;
    end
    chk("no_rsp_after_reset", 64'(pulses), 64'd0);
    chk("rsp_err_after_reset", 64'(rsp_err), 64'd0);

    send_cmd(1'b1, 10'd1, 32'h70, 32'h0BAD_F00D);
    step(idle, mk_inject(1'b1, 10'd1, 32'h70, 32'h0BAD_F00D));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
